radix4_seq_mult: RTL

//  Parametrised unsigned sequential multiplier, successor to the 2x2 partial-product cells.

---
 rtl/radix4_seq_mult.sv | 102 ++++++++++
 1 files changed

// File: rtl/radix4_seq_mult.sv
// Unsigned sequential multiplier: consumes the multiplier one radix-4 digit per cycle.
// Optional EARLY_EXIT_EN finishes as soon as the remaining multiplier digits are all zero.
module radix4_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int CNT_W = $clog2(WIDTH/2) + 1;
    localparam int PW    = 2*WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH/2 - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [PW-1:0]    acc;
    logic [CNT_W-1:0] cnt;

    logic [PW-1:0]    pp;
    logic [PW-1:0]    term;
    logic [PW-1:0]    acc_next;
    logic             last;

    // Digit partial product A*b_r[1:0] built from the two bit-level terms, then weighted by 4^cnt.
    always_comb begin
        pp = '0;
        if (b_r[0]) pp = pp + PW'(a_r);
        if (b_r[1]) pp = pp + (PW'(a_r) << 1);
        term     = pp << {cnt, 1'b0};
        acc_next = acc + term;
`ifdef EARLY_EXIT_EN
        last = (cnt == LAST_CNT) || ((b_r >> 2) == '0);
`else
        last = (cnt == LAST_CNT);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            p         <= '0;
            acc       <= '0;
            cnt       <= '0;
            a_r       <= '0;
            b_r       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    b_r <= b_r >> 2;
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        p         <= acc_next;
                    end
                end
                DONE: begin
                    // p and out_valid hold until the consumer takes the product.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
